// File: rtl/peg_l2_rx_pkt_arb.sv
// Packet-granular round-robin arbiter: two L2 RS RX ports share one MAC RX pipeline.
// The grant locks from SOP to EOP, orphan beats in idle are dropped, and packets longer
// than MAX_PKT_BEATS are cut short with eop+error and their tail discarded.
// Optional statistics counters are enabled by defining PEG_L2_RX_PKT_ARB_STATS_EN.
module peg_l2_rx_pkt_arb #(
    parameter int unsigned PKT_DATA_W    = 64,
    parameter int unsigned PKT_SIZE_W    = 16,
    parameter int unsigned MAX_PKT_BEATS = 200,
    parameter int unsigned BEAT_CNTR_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_p0_pkt_valid,
    input  logic                  i_p0_pkt_sop,
    input  logic                  i_p0_pkt_eop,
    input  logic [PKT_DATA_W-1:0] i_p0_pkt_data,
    input  logic [PKT_SIZE_W-1:0] i_p0_pkt_size,
    input  logic                  i_p0_pkt_error,
    output logic                  o_p0_pkt_ready,
    input  logic                  i_p1_pkt_valid,
    input  logic                  i_p1_pkt_sop,
    input  logic                  i_p1_pkt_eop,
    input  logic [PKT_DATA_W-1:0] i_p1_pkt_data,
    input  logic [PKT_SIZE_W-1:0] i_p1_pkt_size,
    input  logic                  i_p1_pkt_error,
    output logic                  o_p1_pkt_ready,
    input  logic                  i_mac_pkt_ready,
`ifdef PEG_L2_RX_PKT_ARB_STATS_EN
    output logic [31:0]           o_stats_p0_pkt_cnt,
    output logic [31:0]           o_stats_p1_pkt_cnt,
    output logic [15:0]           o_stats_orphan_cnt,
    output logic [15:0]           o_stats_trunc_cnt,
`endif
    output logic                  o_mac_pkt_valid,
    output logic                  o_mac_pkt_sop,
    output logic                  o_mac_pkt_eop,
    output logic [PKT_DATA_W-1:0] o_mac_pkt_data,
    output logic [PKT_SIZE_W-1:0] o_mac_pkt_size,
    output logic                  o_mac_pkt_error,
    output logic                  o_mac_pkt_port
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StXfer    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    localparam logic [BEAT_CNTR_W-1:0] LastBeat = BEAT_CNTR_W'(MAX_PKT_BEATS - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_rr_ptr;
    logic                   w_rr_ptr_nxt;
    logic                   r_grant;
    logic                   w_grant_nxt;
    logic [BEAT_CNTR_W-1:0] r_beat_cntr;
    logic [BEAT_CNTR_W-1:0] w_beat_cntr_nxt;

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_orph0;
    logic                   w_orph1;
    logic                   w_sel_valid;
    logic                   w_sel_sop;
    logic                   w_sel_eop;
    logic [PKT_DATA_W-1:0]  w_sel_data;
    logic [PKT_SIZE_W-1:0]  w_sel_size;
    logic                   w_sel_error;
    logic                   w_trunc;
    logic                   w_mac_hs;
    logic                   w_eop_fwd;
    logic                   w_trunc_fwd;
    logic [1:0]             w_orphan_drops;

    // Request decode and granted-port mux; the data path stays combinational.
    always_comb begin
        w_req0      = i_p0_pkt_valid & i_p0_pkt_sop;
        w_req1      = i_p1_pkt_valid & i_p1_pkt_sop;
        w_orph0     = i_p0_pkt_valid & ~i_p0_pkt_sop;
        w_orph1     = i_p1_pkt_valid & ~i_p1_pkt_sop;
        w_sel_valid = r_grant ? i_p1_pkt_valid : i_p0_pkt_valid;
        w_sel_sop   = r_grant ? i_p1_pkt_sop   : i_p0_pkt_sop;
        w_sel_eop   = r_grant ? i_p1_pkt_eop   : i_p0_pkt_eop;
        w_sel_data  = r_grant ? i_p1_pkt_data  : i_p0_pkt_data;
        w_sel_size  = r_grant ? i_p1_pkt_size  : i_p0_pkt_size;
        w_sel_error = r_grant ? i_p1_pkt_error : i_p0_pkt_error;
        // Last permitted beat without EOP: close the packet ourselves.
        w_trunc     = w_sel_valid & ~w_sel_eop & (r_beat_cntr == LastBeat);
        w_mac_hs    = w_sel_valid & i_mac_pkt_ready;
    end

    // FSM next state, grant/round-robin/beat-count updates and all outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cntr_nxt = r_beat_cntr;
        o_mac_pkt_valid = 1'b0;
        o_mac_pkt_sop   = 1'b0;
        o_mac_pkt_eop   = 1'b0;
        o_mac_pkt_data  = '0;
        o_mac_pkt_size  = '0;
        o_mac_pkt_error = 1'b0;
        o_mac_pkt_port  = 1'b0;
        o_p0_pkt_ready  = 1'b0;
        o_p1_pkt_ready  = 1'b0;
        w_eop_fwd       = 1'b0;
        w_trunc_fwd     = 1'b0;
        w_orphan_drops  = 2'd0;
        unique case (r_state)
            StIdle: begin
                // SOP beats are held for XFER; non-SOP beats are orphans and get flushed.
                o_p0_pkt_ready  = w_orph0;
                o_p1_pkt_ready  = w_orph1;
                w_orphan_drops  = {1'b0, w_orph0} + {1'b0, w_orph1};
                w_beat_cntr_nxt = '0;
                if (w_req0 && w_req1) begin
                    w_grant_nxt = r_rr_ptr;
                    w_state_nxt = StXfer;
                end else if (w_req0) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = StXfer;
                end else if (w_req1) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = StXfer;
                end
            end
            StXfer: begin
                o_mac_pkt_valid = w_sel_valid;
                o_mac_pkt_sop   = w_sel_sop;
                o_mac_pkt_eop   = w_sel_eop | w_trunc;
                o_mac_pkt_data  = w_sel_data;
                o_mac_pkt_size  = w_sel_size;
                o_mac_pkt_error = w_sel_error | w_trunc;
                o_mac_pkt_port  = r_grant;
                if (r_grant) begin
                    o_p1_pkt_ready = i_mac_pkt_ready;
                end else begin
                    o_p0_pkt_ready = i_mac_pkt_ready;
                end
                if (w_mac_hs) begin
                    if (w_sel_eop) begin
                        w_state_nxt     = StIdle;
                        w_rr_ptr_nxt    = ~r_grant;
                        w_beat_cntr_nxt = '0;
                        w_eop_fwd       = 1'b1;
                    end else if (w_trunc) begin
                        w_state_nxt     = StDiscard;
                        w_beat_cntr_nxt = '0;
                        w_trunc_fwd     = 1'b1;
                    end else begin
                        w_beat_cntr_nxt = r_beat_cntr + BEAT_CNTR_W'(1);
                    end
                end
            end
            StDiscard: begin
                // Flush the rest of the runaway packet, including its EOP beat.
                if (r_grant) begin
                    o_p1_pkt_ready = 1'b1;
                end else begin
                    o_p0_pkt_ready = 1'b1;
                end
                if (w_sel_valid && w_sel_eop) begin
                    w_state_nxt  = StIdle;
                    w_rr_ptr_nxt = ~r_grant;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_rr_ptr    <= 1'b0;
            r_grant     <= 1'b0;
            r_beat_cntr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_beat_cntr <= w_beat_cntr_nxt;
        end
    end

`ifdef PEG_L2_RX_PKT_ARB_STATS_EN
    logic [31:0] r_stats_p0_pkt_cnt;
    logic [31:0] r_stats_p1_pkt_cnt;
    logic [15:0] r_stats_orphan_cnt;
    logic [15:0] r_stats_trunc_cnt;
    logic [16:0] w_orphan_sum;
    logic        w_pkt_fwd;

    // A truncated beat reaches the MAC with eop set, so it counts as a forwarded packet.
    always_comb begin
        w_pkt_fwd    = w_eop_fwd | w_trunc_fwd;
        w_orphan_sum = {1'b0, r_stats_orphan_cnt} + {15'd0, w_orphan_drops};
    end

    // Saturating statistics counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stats_p0_pkt_cnt <= '0;
            r_stats_p1_pkt_cnt <= '0;
            r_stats_orphan_cnt <= '0;
            r_stats_trunc_cnt  <= '0;
        end else begin
            if (w_pkt_fwd && !r_grant && (r_stats_p0_pkt_cnt != '1)) begin
                r_stats_p0_pkt_cnt <= r_stats_p0_pkt_cnt + 32'd1;
            end
            if (w_pkt_fwd && r_grant && (r_stats_p1_pkt_cnt != '1)) begin
                r_stats_p1_pkt_cnt <= r_stats_p1_pkt_cnt + 32'd1;
            end
            r_stats_orphan_cnt <= w_orphan_sum[16] ? 16'hFFFF : w_orphan_sum[15:0];
            if (w_trunc_fwd && (r_stats_trunc_cnt != '1)) begin
                r_stats_trunc_cnt <= r_stats_trunc_cnt + 16'd1;
            end
        end
    end

    assign o_stats_p0_pkt_cnt = r_stats_p0_pkt_cnt;
    assign o_stats_p1_pkt_cnt = r_stats_p1_pkt_cnt;
    assign o_stats_orphan_cnt = r_stats_orphan_cnt;
    assign o_stats_trunc_cnt  = r_stats_trunc_cnt;
`endif

endmodule

// File: tb/tb_peg_l2_rx_pkt_arb.sv
// Table-driven bench for peg_l2_rx_pkt_arb (MAX_PKT_BEATS=4 to reach truncation quickly).
// Each row holds one cycle of port stimulus and the outputs expected during that cycle.
// Port error inputs are driven from data bit 7; sizes mirror the data byte.
module tb_peg_l2_rx_pkt_arb;

    localparam int unsigned DW = 64;
    localparam int unsigned SW = 16;

    // Port control codes {valid, sop, eop}
    localparam logic [2:0] NO  = 3'b000;
    localparam logic [2:0] SOP = 3'b110;
    localparam logic [2:0] MID = 3'b100;
    localparam logic [2:0] EOP = 3'b101;
    localparam logic [2:0] ONE = 3'b111;

    typedef struct {
        logic        rst;
        logic [2:0]  p0;
        logic [7:0]  d0;
        logic [2:0]  p1;
        logic [7:0]  d1;
        logic        mr;
        logic [4:0]  exp_ctl;  // {valid, sop, eop, error, port}
        logic [7:0]  exp_d;
        logic [1:0]  exp_rdy;  // {p1_ready, p0_ready}
        string       name;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          p0_valid, p0_sop, p0_eop, p0_error, p0_ready;
    logic [DW-1:0] p0_data;
    logic [SW-1:0] p0_size;
    logic          p1_valid, p1_sop, p1_eop, p1_error, p1_ready;
    logic [DW-1:0] p1_data;
    logic [SW-1:0] p1_size;
    logic          mac_ready;
    logic          mac_valid, mac_sop, mac_eop, mac_error, mac_port;
    logic [DW-1:0] mac_data;
    logic [SW-1:0] mac_size;

    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    peg_l2_rx_pkt_arb #(
        .PKT_DATA_W   (DW),
        .PKT_SIZE_W   (SW),
        .MAX_PKT_BEATS(4),
        .BEAT_CNTR_W  (8)
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_p0_pkt_valid (p0_valid),
        .i_p0_pkt_sop   (p0_sop),
        .i_p0_pkt_eop   (p0_eop),
        .i_p0_pkt_data  (p0_data),
        .i_p0_pkt_size  (p0_size),
        .i_p0_pkt_error (p0_error),
        .o_p0_pkt_ready (p0_ready),
        .i_p1_pkt_valid (p1_valid),
        .i_p1_pkt_sop   (p1_sop),
        .i_p1_pkt_eop   (p1_eop),
        .i_p1_pkt_data  (p1_data),
        .i_p1_pkt_size  (p1_size),
        .i_p1_pkt_error (p1_error),
        .o_p1_pkt_ready (p1_ready),
        .i_mac_pkt_ready(mac_ready),
        .o_mac_pkt_valid(mac_valid),
        .o_mac_pkt_sop  (mac_sop),
        .o_mac_pkt_eop  (mac_eop),
        .o_mac_pkt_data (mac_data),
        .o_mac_pkt_size (mac_size),
        .o_mac_pkt_error(mac_error),
        .o_mac_pkt_port (mac_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst_v, input logic [2:0] c0, input logic [7:0] d0,
                       input logic [2:0] c1, input logic [7:0] d1, input logic mr,
                       input logic [4:0] ctl, input logic [7:0] ed, input logic [1:0] rdy,
                       input string nm);
        vec_t v;
        v.rst = rst_v; v.p0 = c0; v.d0 = d0; v.p1 = c1; v.d1 = d1; v.mr = mr;
        v.exp_ctl = ctl; v.exp_d = ed; v.exp_rdy = rdy; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        mac_ready = v.mr;
        {p0_valid, p0_sop, p0_eop} = v.p0;
        p0_data   = {56'd0, v.d0};
        p0_size   = {8'd0, v.d0};
        p0_error  = v.d0[7];
        {p1_valid, p1_sop, p1_eop} = v.p1;
        p1_data   = {56'd0, v.d1};
        p1_size   = {8'd0, v.d1};
        p1_error  = v.d1[7];
    endtask

    task automatic check(input int idx, input vec_t v);
        logic [4:0]    act_ctl;
        logic [1:0]    act_rdy;
        logic [DW-1:0] exp_data;
        logic [SW-1:0] exp_size;
        act_ctl  = {mac_valid, mac_sop, mac_eop, mac_error, mac_port};
        act_rdy  = {p1_ready, p0_ready};
        exp_data = {56'd0, v.exp_d};
        exp_size = {8'd0, v.exp_d};
        n_tests++;
        if (act_ctl !== v.exp_ctl || act_rdy !== v.exp_rdy || mac_data !== exp_data ||
            mac_size !== exp_size) begin
            n_fail++;
            $display("FAIL %0d %s: got ctl=%b rdy=%b data=%h size=%h, want ctl=%b rdy=%b data=%h size=%h",
                     idx, v.name, act_ctl, act_rdy, mac_data, mac_size,
                     v.exp_ctl, v.exp_rdy, exp_data, exp_size);
        end
    endtask

    initial begin
        vec_t idle_v;
        n_tests = 0;
        n_fail  = 0;

        // 4-beat p0 packet, first beat one cycle after the request
        add(0, NO,  8'h00, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "reset_idle");
        add(0, SOP, 8'h11, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "p0_req");
        add(0, SOP, 8'h11, NO,  8'h00, 1, 5'b11000, 8'h11, 2'b01, "p0_b1_sop");
        add(0, MID, 8'h22, NO,  8'h00, 1, 5'b10000, 8'h22, 2'b01, "p0_b2");
        add(0, MID, 8'h33, NO,  8'h00, 1, 5'b10000, 8'h33, 2'b01, "p0_b3");
        add(0, EOP, 8'h44, NO,  8'h00, 1, 5'b10100, 8'h44, 2'b01, "p0_b4_eop");
        add(0, NO,  8'h00, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "p0_back_idle");
        // Reset in the middle of a p0 packet (rr pointer is 1 going in)
        add(0, SOP, 8'h51, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "rst_req");
        add(0, SOP, 8'h51, NO,  8'h00, 1, 5'b11000, 8'h51, 2'b01, "rst_b1");
        add(1, MID, 8'h52, NO,  8'h00, 1, 5'b10000, 8'h52, 2'b01, "rst_b2_assert");
        add(0, MID, 8'h53, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b01, "rst_after_idle");
        // Simultaneous SOPs: p0 first after reset, then p1 on the next pair
        add(0, SOP, 8'h61, SOP, 8'h71, 1, 5'b00000, 8'h00, 2'b00, "pair1_req");
        add(0, ONE, 8'h61, SOP, 8'h71, 1, 5'b11100, 8'h61, 2'b01, "pair1_p0_single");
        add(0, ONE, 8'h62, SOP, 8'h71, 1, 5'b00000, 8'h00, 2'b00, "pair2_req");
        add(0, ONE, 8'h62, SOP, 8'h71, 1, 5'b11001, 8'h71, 2'b10, "pair2_p1_b1");
        add(0, ONE, 8'h62, EOP, 8'h72, 1, 5'b10101, 8'h72, 2'b10, "pair2_p1_b2_eop");
        add(0, ONE, 8'h62, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "pair2_p0_req");
        add(0, ONE, 8'h62, NO,  8'h00, 1, 5'b11100, 8'h62, 2'b01, "pair2_p0_single");
        // mac_pkt_ready toggles during a 3-beat p1 packet; last beat carries error
        add(0, NO,  8'h00, SOP, 8'h54, 1, 5'b00000, 8'h00, 2'b00, "tog_req");
        add(0, NO,  8'h00, SOP, 8'h54, 1, 5'b11001, 8'h54, 2'b10, "tog_b1");
        add(0, NO,  8'h00, MID, 8'h55, 0, 5'b10001, 8'h55, 2'b00, "tog_stall1");
        add(0, NO,  8'h00, MID, 8'h55, 0, 5'b10001, 8'h55, 2'b00, "tog_stall2");
        add(0, NO,  8'h00, MID, 8'h55, 1, 5'b10001, 8'h55, 2'b10, "tog_b2");
        add(0, NO,  8'h00, EOP, 8'h88, 1, 5'b10111, 8'h88, 2'b10, "tog_b3_err");
        // Orphan beat on p0 in idle
        add(0, MID, 8'h99, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b01, "orphan_drop");
        add(0, NO,  8'h00, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "orphan_after");
        // 6-beat p1 packet truncated at beat 4
        add(0, NO,  8'h00, SOP, 8'h31, 1, 5'b00000, 8'h00, 2'b00, "trunc_req");
        add(0, NO,  8'h00, SOP, 8'h31, 1, 5'b11001, 8'h31, 2'b10, "trunc_b1");
        add(0, NO,  8'h00, MID, 8'h32, 1, 5'b10001, 8'h32, 2'b10, "trunc_b2");
        add(0, NO,  8'h00, MID, 8'h33, 1, 5'b10001, 8'h33, 2'b10, "trunc_b3");
        add(0, NO,  8'h00, MID, 8'h34, 1, 5'b10111, 8'h34, 2'b10, "trunc_b4_cut");
        add(0, NO,  8'h00, MID, 8'h35, 1, 5'b00000, 8'h00, 2'b10, "trunc_drop5");
        add(0, NO,  8'h00, EOP, 8'h36, 1, 5'b00000, 8'h00, 2'b10, "trunc_drop6_eop");
        add(0, NO,  8'h00, ONE, 8'h41, 1, 5'b00000, 8'h00, 2'b00, "trunc_recover_req");
        add(0, NO,  8'h00, ONE, 8'h41, 1, 5'b11101, 8'h41, 2'b10, "trunc_recover_pkt");
        add(0, NO,  8'h00, NO,  8'h00, 1, 5'b00000, 8'h00, 2'b00, "final_idle");

        // Two reset cycles with quiet ports before the table starts
        idle_v = vecs[0];
        idle_v.rst = 1'b1;
        drive(idle_v);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check(i, vecs[i]);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
